atm_keypad_entry: RTL and testbench

// Front-end stage upstream of the ATM controller. Collects keypad key codes, assembles account number,
// PIN, operation, amount and new PIN as binary fields, and offers one complete transaction to the ATM

---
 rtl/atm_keypad_entry_if.sv | 41 ++++
 rtl/atm_keypad_entry.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_atm_keypad_entry.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_keypad_entry_if.sv
// rtl/atm_keypad_entry_if.sv - keypad-entry bus: key input, language select and transaction handshake
//
// Signals
//   key_valid, key_code[3:0]  keypad strobe and key (0-9 digit, 10 ENTER, 11 CLEAR, 12 CANCEL)
//   lang_sel                  language select sampled when an entry starts
//   txn_ready                 controller accepts the offered transaction
//   txn_valid                 transaction complete and held stable
//   operation[2:0], acc_num[3:0], pin[13:0], new_pin[13:0], amount[13:0], language
//   key_err, timeout          one-cycle status pulses
//   entry_state[2:0]          current entry state
// Modports
//   master : keypad / controller side (drives keys and txn_ready)
//   slave  : atm_keypad_entry
interface atm_keypad_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        lang_sel;
    logic        txn_ready;
    logic        txn_valid;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [13:0] pin;
    logic [13:0] new_pin;
    logic [13:0] amount;
    logic        language;
    logic        key_err;
    logic        timeout;
    logic [2:0]  entry_state;

    modport master (
        output key_valid, key_code, lang_sel, txn_ready,
        input  txn_valid, operation, acc_num, pin, new_pin, amount,
        input  language, key_err, timeout, entry_state
    );

    modport slave (
        input  key_valid, key_code, lang_sel, txn_ready,
        output txn_valid, operation, acc_num, pin, new_pin, amount,
        output language, key_err, timeout, entry_state
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// rtl/atm_keypad_entry.sv - keypad transaction assembler in front of the ATM controller
//
// Collects key codes into account number, PIN, operation, amount and new PIN, then offers
// the complete transaction with a valid/ready handshake. No account or PIN validation here.
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  atm_keypad_entry_if.slave (key input, lang_sel, txn handshake, fields, pulses, state)
// Parameters
//   MAX_ACC, PIN_DIGITS, AMT_MAX, TIMEOUT_CYCLES
// Configuration macro
//   ATM_KEYPAD_TIMEOUT_EN - enables the inactivity timeout; when undefined timeout is always 0
module atm_keypad_entry #(
    parameter int MAX_ACC        = 10,
    parameter int PIN_DIGITS     = 4,
    parameter int AMT_MAX        = 10000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    atm_keypad_entry_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_PIN  = 3'd2,
        S_OP   = 3'd3,
        S_AMT  = 3'd4,
        S_NPIN = 3'd5,
        S_SEND = 3'd6
    } state_t;

    localparam logic [3:0] K_ENTER  = 4'd10;
    localparam logic [3:0] K_CLEAR  = 4'd11;
    localparam logic [3:0] K_CANCEL = 4'd12;
    localparam int         CNT_W    = $clog2(PIN_DIGITS + 1);

    state_t             state;
    logic               txn_valid_q;
    logic [2:0]         op_q;
    logic [3:0]         acc_q;
    logic [13:0]        pin_q;
    logic [13:0]        npin_q;
    logic [13:0]        amt_q;
    logic               lang_q;
    logic               key_err_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   dcnt_q;

    logic               is_digit;
    logic               active;
    logic               abort;
    logic               to_fire;
    logic               pin_room;
    logic [16:0]        acc_ext;
    logic [16:0]        pin_ext;
    logic [16:0]        npin_ext;
    logic [16:0]        amt_ext;

    assign is_digit = (bus.key_code <= 4'd9);
    assign active   = (state == S_ACC) || (state == S_PIN) || (state == S_OP) ||
                      (state == S_AMT) || (state == S_NPIN);
    assign abort    = active && bus.key_valid && (bus.key_code == K_CANCEL);
    assign pin_room = (dcnt_q < CNT_W'(PIN_DIGITS));

    // Wide accumulate so the limit compare sees the true value before truncation.
    assign acc_ext  = 17'(acc_q)  * 17'd10 + 17'(bus.key_code);
    assign pin_ext  = 17'(pin_q)  * 17'd10 + 17'(bus.key_code);
    assign npin_ext = 17'(npin_q) * 17'd10 + 17'(bus.key_code);
    assign amt_ext  = 17'(amt_q)  * 17'd10 + 17'(bus.key_code);

`ifdef ATM_KEYPAD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;

    // Held at zero outside the entry states, so entry into ACC always starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (bus.key_valid || !active) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_fire = active && !bus.key_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign to_fire            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            txn_valid_q <= 1'b0;
            op_q        <= '0;
            acc_q       <= '0;
            pin_q       <= '0;
            npin_q      <= '0;
            amt_q       <= '0;
            lang_q      <= 1'b0;
            key_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            dcnt_q      <= '0;
        end else begin
            key_err_q <= 1'b0;
            timeout_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.key_valid && is_digit) begin
                        op_q   <= '0;
                        pin_q  <= '0;
                        npin_q <= '0;
                        amt_q  <= '0;
                        dcnt_q <= '0;
                        lang_q <= bus.lang_sel;
                        acc_q  <= bus.key_code;
                        state  <= S_ACC;
                    end
                end

                S_ACC: begin
                    if (bus.key_valid) begin
                        if (is_digit) begin
                            if (acc_ext > 17'(MAX_ACC)) begin
                                key_err_q <= 1'b1;
                            end else begin
                                acc_q <= acc_ext[3:0];
                            end
                        end else if (bus.key_code == K_ENTER) begin
                            if (acc_q != 4'd0 && 17'(acc_q) <= 17'(MAX_ACC)) begin
                                dcnt_q <= '0;
                                state  <= S_PIN;
                            end else begin
                                key_err_q <= 1'b1;
                            end
                        end else if (bus.key_code == K_CLEAR) begin
                            acc_q  <= '0;
                            dcnt_q <= '0;
                        end
                    end
                end

                S_PIN: begin
                    if (bus.key_valid) begin
                        if (is_digit) begin
                            if (pin_room) begin
                                pin_q  <= pin_ext[13:0];
                                dcnt_q <= dcnt_q + 1'b1;
                            end else begin
                                key_err_q <= 1'b1;
                            end
                        end else if (bus.key_code == K_ENTER) begin
                            if (dcnt_q == CNT_W'(PIN_DIGITS)) begin
                                state <= S_OP;
                            end else begin
                                key_err_q <= 1'b1;
                            end
                        end else if (bus.key_code == K_CLEAR) begin
                            pin_q  <= '0;
                            dcnt_q <= '0;
                        end
                    end
                end

                S_OP: begin
                    // Operation is a single digit; ENTER and CLEAR have no meaning here.
                    if (bus.key_valid && is_digit) begin
                        case (bus.key_code)
                            4'd3: begin
                                op_q        <= 3'd3;
                                txn_valid_q <= 1'b1;
                                state       <= S_SEND;
                            end
                            4'd4, 4'd5: begin
                                op_q  <= bus.key_code[2:0];
                                amt_q <= '0;
                                state <= S_AMT;
                            end
                            4'd6: begin
                                op_q   <= 3'd6;
                                dcnt_q <= '0;
                                state  <= S_NPIN;
                            end
                            default: key_err_q <= 1'b1;
                        endcase
                    end
                end

                S_AMT: begin
                    if (bus.key_valid) begin
                        if (is_digit) begin
                            if (amt_ext > 17'(AMT_MAX)) begin
                                key_err_q <= 1'b1;
                            end else begin
                                amt_q <= amt_ext[13:0];
                            end
                        end else if (bus.key_code == K_ENTER) begin
                            if (amt_q != 14'd0) begin
                                txn_valid_q <= 1'b1;
                                state       <= S_SEND;
                            end else begin
                                key_err_q <= 1'b1;
                            end
                        end else if (bus.key_code == K_CLEAR) begin
                            amt_q  <= '0;
                            dcnt_q <= '0;
                        end
                    end
                end

                S_NPIN: begin
                    if (bus.key_valid) begin
                        if (is_digit) begin
                            if (pin_room) begin
                                npin_q <= npin_ext[13:0];
                                dcnt_q <= dcnt_q + 1'b1;
                            end else begin
                                key_err_q <= 1'b1;
                            end
                        end else if (bus.key_code == K_ENTER) begin
                            if (dcnt_q == CNT_W'(PIN_DIGITS)) begin
                                txn_valid_q <= 1'b1;
                                state       <= S_SEND;
                            end else begin
                                key_err_q <= 1'b1;
                            end
                        end else if (bus.key_code == K_CLEAR) begin
                            npin_q <= '0;
                            dcnt_q <= '0;
                        end
                    end
                end

                S_SEND: begin
                    // Fields stay as they are after transfer until the next entry starts.
                    if (bus.txn_ready) begin
                        txn_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    txn_valid_q <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase

            // CANCEL and inactivity both abandon the entry; placed last so they win.
            if (abort || to_fire) begin
                state       <= S_IDLE;
                txn_valid_q <= 1'b0;
                op_q        <= '0;
                acc_q       <= '0;
                pin_q       <= '0;
                npin_q      <= '0;
                amt_q       <= '0;
                lang_q      <= 1'b0;
                dcnt_q      <= '0;
                key_err_q   <= 1'b0;
                timeout_q   <= to_fire;
            end
        end
    end

    assign bus.txn_valid   = txn_valid_q;
    assign bus.operation   = op_q;
    assign bus.acc_num     = acc_q;
    assign bus.pin         = pin_q;
    assign bus.new_pin     = npin_q;
    assign bus.amount      = amt_q;
    assign bus.language    = lang_q;
    assign bus.key_err     = key_err_q;
    assign bus.timeout     = timeout_q;
    assign bus.entry_state = state;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb/tb_atm_keypad_entry.sv - directed self-checking bench for atm_keypad_entry
module tb_atm_keypad_entry;

    logic clk = 1'b0;
    logic rst = 1'b1;

    atm_keypad_entry_if bus();

    atm_keypad_entry #(
        .MAX_ACC(10),
        .PIN_DIGITS(4),
        .AMT_MAX(10000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int valid_cycles   = 0;
    int timeout_cycles = 0;

    always @(negedge clk) begin
        if (bus.txn_valid === 1'b1) valid_cycles++;
        if (bus.timeout === 1'b1) timeout_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic press(input logic [3:0] k, output logic err);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd15;
        err = bus.key_err;
    endtask

    // Presses the n low nibbles of seq, most significant first (A=ENTER, B=CLEAR, C=CANCEL).
    task automatic press_hex(input logic [63:0] seq, input int n, output int errs, output logic last);
        logic e;
        errs = 0;
        last = 1'b0;
        for (int i = 0; i < n; i++) begin
            press(seq[(n-1-i)*4 +: 4], e);
            errs += int'(e);
            last = e;
        end
    endtask

    task automatic test_reset();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd15;
        bus.lang_sel  = 1'b0;
        bus.txn_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.entry_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", bus.entry_state);
        else n_pass++;
        n_total++;
        if ({bus.txn_valid, bus.key_err, bus.timeout, bus.acc_num, bus.pin, bus.amount} !== '0)
            $display("FAIL reset_outputs: got valid=%b err=%b to=%b acc=%0d pin=%0d amt=%0d expected all 0",
                     bus.txn_valid, bus.key_err, bus.timeout, bus.acc_num, bus.pin, bus.amount);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        int errs;
        logic last;
        bus.lang_sel = 1'b1;
        press_hex(64'h7A7890A4500A, 12, errs, last);
        bus.lang_sel = 1'b0;
        n_total++;
        if (errs !== 0) $display("FAIL wd_errs: got %0d key errors expected 0", errs);
        else n_pass++;
        n_total++;
        if (bus.txn_valid !== 1'b1 || bus.entry_state !== 3'd6)
            $display("FAIL wd_valid: got valid=%b state=%0d expected 1/6", bus.txn_valid, bus.entry_state);
        else n_pass++;
        n_total++;
        if (bus.acc_num !== 4'd7 || bus.pin !== 14'd7890 || bus.operation !== 3'd4 ||
            bus.amount !== 14'd500 || bus.new_pin !== 14'd0 || bus.language !== 1'b1)
            $display("FAIL wd_fields: got acc=%0d pin=%0d op=%0d amt=%0d npin=%0d lang=%b expected 7/7890/4/500/0/1",
                     bus.acc_num, bus.pin, bus.operation, bus.amount, bus.new_pin, bus.language);
        else n_pass++;
        repeat (3) @(negedge clk);
        press(4'd12, last);
        n_total++;
        if (bus.txn_valid !== 1'b1 || bus.acc_num !== 4'd7 || bus.pin !== 14'd7890 || bus.amount !== 14'd500)
            $display("FAIL wd_stable: got valid=%b acc=%0d pin=%0d amt=%0d expected 1/7/7890/500",
                     bus.txn_valid, bus.acc_num, bus.pin, bus.amount);
        else n_pass++;
        @(negedge clk);
        bus.txn_ready = 1'b1;
        @(negedge clk);
        bus.txn_ready = 1'b0;
        n_total++;
        if (bus.txn_valid !== 1'b0 || bus.entry_state !== 3'd0 || bus.acc_num !== 4'd7 || bus.amount !== 14'd500)
            $display("FAIL wd_accept: got valid=%b state=%0d acc=%0d amt=%0d expected 0/0/7/500",
                     bus.txn_valid, bus.entry_state, bus.acc_num, bus.amount);
        else n_pass++;
    endtask

    task automatic test_acc_limit();
        int errs;
        logic last;
        press_hex(64'h105, 3, errs, last);
        n_total++;
        if (errs !== 1 || last !== 1'b1 || bus.acc_num !== 4'd10)
            $display("FAIL acc_over: got errs=%0d last=%b acc=%0d expected 1/1/10", errs, last, bus.acc_num);
        else n_pass++;
        press(4'd12, last);
        press_hex(64'h0A, 2, errs, last);
        n_total++;
        if (last !== 1'b1 || bus.entry_state !== 3'd1)
            $display("FAIL acc_zero: got err=%b state=%0d expected 1/1", last, bus.entry_state);
        else n_pass++;
        press(4'd12, last);
    endtask

    task automatic test_pin_limits();
        int errs;
        int v0;
        logic last;
        v0 = valid_cycles;
        press_hex(64'h3A123A, 6, errs, last);
        n_total++;
        if (last !== 1'b1 || bus.entry_state !== 3'd2)
            $display("FAIL pin_short: got err=%b state=%0d expected 1/2", last, bus.entry_state);
        else n_pass++;
        press(4'd11, last);
        n_total++;
        if (bus.pin !== 14'd0 || last !== 1'b0)
            $display("FAIL pin_clear: got pin=%0d err=%b expected 0/0", bus.pin, last);
        else n_pass++;
        press_hex(64'h45678, 5, errs, last);
        n_total++;
        if (errs !== 1 || last !== 1'b1 || bus.pin !== 14'd4567)
            $display("FAIL pin_extra: got errs=%0d last=%b pin=%0d expected 1/1/4567", errs, last, bus.pin);
        else n_pass++;
        press_hex(64'hA8, 2, errs, last);
        n_total++;
        if (errs !== 1 || last !== 1'b1 || bus.entry_state !== 3'd3)
            $display("FAIL op_bad: got errs=%0d last=%b state=%0d expected 1/1/3", errs, last, bus.entry_state);
        else n_pass++;
        press_hex(64'h612C, 4, errs, last);
        n_total++;
        if (bus.entry_state !== 3'd0 || bus.acc_num !== 4'd0 || bus.pin !== 14'd0 ||
            bus.new_pin !== 14'd0 || bus.operation !== 3'd0 || valid_cycles !== v0)
            $display("FAIL npin_cancel: got state=%0d acc=%0d pin=%0d npin=%0d op=%0d valid_cycles=%0d expected 0/0/0/0/0/%0d",
                     bus.entry_state, bus.acc_num, bus.pin, bus.new_pin, bus.operation, valid_cycles, v0);
        else n_pass++;
    endtask

    task automatic test_amount();
        int errs;
        logic last;
        press_hex(64'h1A1111A5, 8, errs, last);
        press(4'd10, last);
        n_total++;
        if (last !== 1'b1 || bus.entry_state !== 3'd4)
            $display("FAIL amt_zero: got err=%b state=%0d expected 1/4", last, bus.entry_state);
        else n_pass++;
        press_hex(64'h10000, 5, errs, last);
        n_total++;
        if (errs !== 0 || bus.amount !== 14'd10000)
            $display("FAIL amt_max: got errs=%0d amt=%0d expected 0/10000", errs, bus.amount);
        else n_pass++;
        press_hex(64'hB10001, 6, errs, last);
        n_total++;
        if (errs !== 1 || last !== 1'b1 || bus.amount !== 14'd1000)
            $display("FAIL amt_over: got errs=%0d last=%b amt=%0d expected 1/1/1000", errs, last, bus.amount);
        else n_pass++;
        press(4'd10, last);
        n_total++;
        if (bus.txn_valid !== 1'b1 || bus.operation !== 3'd5 || bus.amount !== 14'd1000 || bus.acc_num !== 4'd1)
            $display("FAIL amt_send: got valid=%b op=%0d amt=%0d acc=%0d expected 1/5/1000/1",
                     bus.txn_valid, bus.operation, bus.amount, bus.acc_num);
        else n_pass++;
        @(negedge clk);
        bus.txn_ready = 1'b1;
        @(negedge clk);
        bus.txn_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int errs;
        logic last;
        press_hex(64'h2A2345A3, 8, errs, last);
        n_total++;
        if (errs !== 0 || bus.txn_valid !== 1'b1 || bus.operation !== 3'd3 || bus.acc_num !== 4'd2 ||
            bus.pin !== 14'd2345 || bus.amount !== 14'd0 || bus.new_pin !== 14'd0)
            $display("FAIL op3: got errs=%0d valid=%b op=%0d acc=%0d pin=%0d amt=%0d npin=%0d expected 0/1/3/2/2345/0/0",
                     errs, bus.txn_valid, bus.operation, bus.acc_num, bus.pin, bus.amount, bus.new_pin);
        else n_pass++;
        @(negedge clk);
        bus.txn_ready = 1'b1;
        @(negedge clk);
        bus.txn_ready = 1'b0;
        press_hex(64'h4A1111A61A, 10, errs, last);
        n_total++;
        if (errs !== 1 || last !== 1'b1 || bus.entry_state !== 3'd5)
            $display("FAIL npin_short: got errs=%0d last=%b state=%0d expected 1/1/5", errs, last, bus.entry_state);
        else n_pass++;
        press_hex(64'h111A, 4, errs, last);
        n_total++;
        if (errs !== 0 || bus.txn_valid !== 1'b1 || bus.operation !== 3'd6 || bus.new_pin !== 14'd1111 ||
            bus.pin !== 14'd1111 || bus.amount !== 14'd0 || bus.acc_num !== 4'd4)
            $display("FAIL npin_send: got errs=%0d valid=%b op=%0d npin=%0d pin=%0d amt=%0d acc=%0d expected 0/1/6/1111/1111/0/4",
                     errs, bus.txn_valid, bus.operation, bus.new_pin, bus.pin, bus.amount, bus.acc_num);
        else n_pass++;
        @(negedge clk);
        bus.txn_ready = 1'b1;
        @(negedge clk);
        bus.txn_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int errs;
        int t0;
        logic last;
        press_hex(64'h5A, 2, errs, last);
        t0 = timeout_cycles;
`ifdef ATM_KEYPAD_TIMEOUT_EN
        repeat (15) @(negedge clk);
        n_total++;
        if (bus.timeout !== 1'b0 || bus.entry_state !== 3'd2)
            $display("FAIL to_early: got timeout=%b state=%0d expected 0/2", bus.timeout, bus.entry_state);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.timeout !== 1'b1 || bus.entry_state !== 3'd0 || bus.acc_num !== 4'd0)
            $display("FAIL to_fire: got timeout=%b state=%0d acc=%0d expected 1/0/0",
                     bus.timeout, bus.entry_state, bus.acc_num);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.timeout !== 1'b0 || timeout_cycles !== t0 + 1)
            $display("FAIL to_pulse: got timeout=%b pulses=%0d expected 0/%0d", bus.timeout, timeout_cycles - t0, 1);
        else n_pass++;
`else
        repeat (40) @(negedge clk);
        n_total++;
        if (bus.entry_state !== 3'd2 || timeout_cycles !== t0)
            $display("FAIL to_off: got state=%0d pulses=%0d expected 2/0", bus.entry_state, timeout_cycles - t0);
        else n_pass++;
        press(4'd12, last);
`endif
    endtask

    task automatic test_reset_in_send();
        int errs;
        logic last;
        press_hex(64'h9A9999A3, 8, errs, last);
        n_total++;
        if (bus.txn_valid !== 1'b1)
            $display("FAIL rst_pre: got valid=%b expected 1", bus.txn_valid);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus.txn_valid, bus.operation, bus.acc_num, bus.pin, bus.entry_state} !== '0)
            $display("FAIL rst_async: got valid=%b op=%0d acc=%0d pin=%0d state=%0d expected all 0",
                     bus.txn_valid, bus.operation, bus.acc_num, bus.pin, bus.entry_state);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_withdraw();
        test_acc_limit();
        test_pin_limits();
        test_amount();
        test_back_to_back();
        test_timeout();
        test_reset_in_send();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
